rx_word: RTL

//  Host->FPGA UART word receiver, the counterpart of the correlator's hex-word transmitter.

---
 rtl/rx_word_pkg.sv | 43 ++++
 rtl/rx_word_if.sv | 26 ++
 rtl/uart_rx.sv | 101 ++++++++++
 rtl/rx_word.sv | 82 ++++++++
 4 files changed

// File: rtl/rx_word_pkg.sv
// rtl/rx_word_pkg.sv - shared types, characters and hex decode for rx_word
// Optional feature macro: RX_WORD_LOWERCASE_EN (accept 'a'-'f' as hex digits).
package rx_word_pkg;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  localparam logic [7:0] CHAR_CR = 8'h0d;
  localparam logic [7:0] CHAR_LF = 8'h0a;

`ifdef RX_WORD_LOWERCASE_EN
  localparam bit LOWERCASE_EN = 1'b1;
`else
  localparam bit LOWERCASE_EN = 1'b0;
`endif

  typedef struct packed {
    logic       is_hex;
    logic [3:0] nibble;
  } hex_t;

  function automatic hex_t hex_decode(input logic [7:0] c);
    hex_t r;
    r.is_hex = 1'b0;
    r.nibble = 4'h0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r.is_hex = 1'b1;
      r.nibble = c[3:0];
    end else if (c >= 8'h41 && c <= 8'h46) begin
      r.is_hex = 1'b1;
      r.nibble = c[3:0] + 4'd9;
    end else if (LOWERCASE_EN && c >= 8'h61 && c <= 8'h66) begin
      r.is_hex = 1'b1;
      r.nibble = c[3:0] + 4'd9;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_word_if.sv
// rtl/rx_word_if.sv - UART line, enable and received-word outputs of rx_word
interface rx_word_if #(
  parameter int RESOLUTION = 32
);
  logic                  RX;
  logic                  enable;
  logic [RESOLUTION-1:0] rx_data;
  logic                  valid;
  logic                  err;

  modport master (
    output RX,
    output enable,
    input  rx_data,
    input  valid,
    input  err
  );

  modport slave (
    input  RX,
    input  enable,
    output rx_data,
    output valid,
    output err
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART byte receiver, bit period 2**SHIFT clocks
module uart_rx
  import rx_word_pkg::*;
#(
  parameter int SHIFT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       enable,
  output logic [7:0] data,
  output logic       strobe,
  output logic       frame_err
);

  localparam int HALF_I = 1 << (SHIFT - 1);
  localparam logic [SHIFT-1:0] HALF = HALF_I[SHIFT-1:0];
  localparam logic [SHIFT-1:0] LAST = '1;

  logic              rx_meta;
  logic              line;
  uart_state_t       state;
  logic              armed;
  logic [SHIFT-1:0]  tick;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;

  // Synchroniser resets low so a line still low at release cannot arm the receiver.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b0;
      line    <= 1'b0;
    end else begin
      rx_meta <= RX;
      line    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= UART_IDLE;
      armed     <= 1'b0;
      tick      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      strobe    <= 1'b0;
      frame_err <= 1'b0;
    end else if (!enable) begin
      state     <= UART_IDLE;
      armed     <= 1'b0;
      tick      <= '0;
      strobe    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      strobe    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        UART_IDLE: begin
          tick <= '0;
          if (!armed) begin
            armed <= line;
          end else if (!line) begin
            state <= UART_START;
          end
        end
        UART_START: begin
          tick <= tick + 1'b1;
          if (tick == HALF) begin
            tick    <= '0;
            bit_idx <= '0;
            state   <= line ? UART_IDLE : UART_DATA;
          end
        end
        UART_DATA: begin
          tick <= tick + 1'b1;
          if (tick == LAST) begin
            shreg   <= {line, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= UART_STOP;
          end
        end
        UART_STOP: begin
          tick <= tick + 1'b1;
          if (tick == LAST) begin
            state <= UART_IDLE;
            if (line) begin
              data   <= shreg;
              strobe <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              armed     <= 1'b0;
            end
          end
        end
        default: state <= UART_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rx_word.sv
// rtl/rx_word.sv - UART hex-word receiver: CR-terminated ASCII hex to a parallel word
// Lowercase hex digits are accepted only when RX_WORD_LOWERCASE_EN is defined.
module rx_word
  import rx_word_pkg::*;
#(
  parameter int SHIFT         = 4,
  parameter int RESOLUTION    = 32,
  parameter int TOTAL_NIBBLES = RESOLUTION / 4
) (
  input logic        clk,
  input logic        rst,
  rx_word_if.slave   bus
);

  localparam int CW = $clog2(TOTAL_NIBBLES + 1);
  localparam logic [CW-1:0] FULL = CW'(TOTAL_NIBBLES);

  logic [7:0]            data;
  logic                  strobe;
  logic                  frame_err;
  logic [RESOLUTION-1:0] shreg;
  logic [CW-1:0]         count;
  logic                  overflow;
  hex_t                  hx;

  uart_rx #(.SHIFT(SHIFT)) u_uart_rx (
    .clk       (clk),
    .rst       (rst),
    .RX        (bus.RX),
    .enable    (bus.enable),
    .data      (data),
    .strobe    (strobe),
    .frame_err (frame_err)
  );

  assign hx = hex_decode(data);

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg       <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      bus.rx_data <= '0;
      bus.valid   <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      bus.err   <= 1'b0;
      if (!bus.enable) begin
        count    <= '0;
        overflow <= 1'b0;
      end else if (frame_err) begin
        count    <= '0;
        overflow <= 1'b0;
        bus.err  <= 1'b1;
      end else if (strobe) begin
        if (hx.is_hex) begin
          if (count == FULL) begin
            overflow <= 1'b1;
          end else begin
            shreg <= (shreg << 4) | RESOLUTION'(hx.nibble);
            count <= count + 1'b1;
          end
        end else if (data == CHAR_CR) begin
          if (count == FULL && !overflow) begin
            bus.rx_data <= shreg;
            bus.valid   <= 1'b1;
          end else begin
            bus.err <= 1'b1;
          end
          count    <= '0;
          overflow <= 1'b0;
        end else if (data != CHAR_LF) begin
          bus.err  <= 1'b1;
          count    <= '0;
          overflow <= 1'b0;
        end
      end
    end
  end

endmodule
